// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches and jumps from the comparator flags, checks the result
// against the static prediction, and runs the redirect handshake and flush on a mispredict.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic             lsr_i,
  input  logic             lsrU_i,
  input  logic             eql_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic             pred_taken_i,
  output logic             taken_o,
  output logic             illegal_o,
  output logic             link_valid_o,
  output logic [XLEN-1:0]  link_o,
  output logic             redir_valid_o,
  input  logic             redir_ready_i,
  output logic [XLEN-1:0]  redir_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              br_ready_q, br_ready_d;
  logic              taken_q, taken_d;
  logic              illegal_q, illegal_d;
  logic              link_valid_q, link_valid_d;
  logic [XLEN-1:0]   link_q, link_d;
  logic              redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic              accept, is_cond, is_illegal, cond_taken, res_taken, mispred;
  logic [XLEN-1:0]   fall_pc, branch_tgt, jalr_sum, target, resolved_pc;

  always_comb begin
    accept     = br_valid_i & br_ready_q;
    is_cond    = ~is_jal_i & ~is_jalr_i;
    is_illegal = (is_jal_i & is_jalr_i) |
                 (is_cond & ((funct3_i == 3'b010) | (funct3_i == 3'b011)));

    case (funct3_i)
      3'b000:  cond_taken = eql_i;
      3'b001:  cond_taken = ~eql_i;
      3'b100:  cond_taken = lsr_i;
      3'b101:  cond_taken = ~lsr_i;
      3'b110:  cond_taken = lsrU_i;
      3'b111:  cond_taken = ~lsrU_i;
      default: cond_taken = 1'b0;
    endcase

    res_taken   = is_cond ? cond_taken : 1'b1;
    fall_pc     = pc_i + XLEN'(4);
    branch_tgt  = pc_i + imm_i;
    jalr_sum    = rs1_i + imm_i;
    target      = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : branch_tgt;
    resolved_pc = res_taken ? target : fall_pc;
    // Fetch never predicts a JALR target, so every JALR redirects.
    mispred     = is_jalr_i | (is_jal_i & ~pred_taken_i) |
                  (is_cond & (cond_taken != pred_taken_i));
  end

  always_comb begin
    state_d       = state_q;
    taken_d       = taken_q;
    illegal_d     = 1'b0;
    link_valid_d  = 1'b0;
    link_d        = link_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = 1'b0;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
            taken_d   = 1'b0;
          end else begin
            taken_d  = res_taken;
            br_cnt_d = (br_cnt_q == {CNT_W{1'b1}}) ? br_cnt_q : br_cnt_q + CNT_W'(1);
            if (!is_cond) begin
              link_valid_d = 1'b1;
              link_d       = fall_pc;
            end
            if (mispred) begin
              mis_cnt_d     = (mis_cnt_q == {CNT_W{1'b1}}) ? mis_cnt_q : mis_cnt_q + CNT_W'(1);
              redir_valid_d = 1'b1;
              redir_pc_d    = resolved_pc;
              state_d       = S_REDIRECT;
            end
          end
        end
      end
      S_REDIRECT: begin
        if (redir_ready_i) begin
          redir_valid_d = 1'b0;
          flush_d       = 1'b1;
          state_d       = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    br_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      br_ready_q    <= 1'b1;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      link_valid_q  <= 1'b0;
      link_q        <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      br_ready_q    <= br_ready_d;
      taken_q       <= taken_d;
      illegal_q     <= illegal_d;
      link_valid_q  <= link_valid_d;
      link_q        <= link_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign br_ready_o      = br_ready_q;
  assign taken_o         = taken_q;
  assign illegal_o       = illegal_q;
  assign link_valid_o    = link_valid_q;
  assign link_o          = link_q;
  assign redir_valid_o   = redir_valid_q;
  assign redir_pc_o      = redir_pc_q;
  assign flush_o         = flush_q;
  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected outcomes are queued at accept
// and compared in the following cycle; a second instance with 2-bit counters covers saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid_i, br_ready_o;
  logic [2:0]  funct3_i;
  logic        is_jal_i, is_jalr_i, lsr_i, lsrU_i, eql_i, pred_taken_i;
  logic [31:0] pc_i, imm_i, rs1_i;
  logic        taken_o, illegal_o, link_valid_o, redir_valid_o, redir_ready_i, flush_o;
  logic [31:0] link_o, redir_pc_o;
  logic [15:0] br_count_o, mispred_count_o;

  logic        s_br_ready, s_taken, s_illegal, s_link_valid, s_redir_valid, s_flush;
  logic [31:0] s_link, s_redir_pc;
  logic [1:0]  s_br_count, s_mis_count;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mis = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        jal, jalr, lsr, lsru, eql;
    logic [31:0] pc, imm, rs1;
    logic        pred;
    logic [3:0]  flags;  // {taken, illegal, link_valid, redir_valid}
    logic [31:0] link, rpc;
  } vec_t;

  vec_t exp_q[$];
  vec_t e;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .br_valid_i(br_valid_i), .br_ready_o(br_ready_o),
    .funct3_i(funct3_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .lsr_i(lsr_i), .lsrU_i(lsrU_i), .eql_i(eql_i), .pc_i(pc_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .pred_taken_i(pred_taken_i), .taken_o(taken_o), .illegal_o(illegal_o),
    .link_valid_o(link_valid_o), .link_o(link_o), .redir_valid_o(redir_valid_o),
    .redir_ready_i(redir_ready_i), .redir_pc_o(redir_pc_o), .flush_o(flush_o),
    .br_count_o(br_count_o), .mispred_count_o(mispred_count_o)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_valid_i(br_valid_i), .br_ready_o(s_br_ready),
    .funct3_i(funct3_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .lsr_i(lsr_i), .lsrU_i(lsrU_i), .eql_i(eql_i), .pc_i(pc_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .pred_taken_i(pred_taken_i), .taken_o(s_taken), .illegal_o(s_illegal),
    .link_valid_o(s_link_valid), .link_o(s_link), .redir_valid_o(s_redir_valid),
    .redir_ready_i(redir_ready_i), .redir_pc_o(s_redir_pc), .flush_o(s_flush),
    .br_count_o(s_br_count), .mispred_count_o(s_mis_count)
  );

  function automatic logic [3:0] flags();
    return {taken_o, illegal_o, link_valid_o, redir_valid_o};
  endfunction

  function automatic vec_t mk(input logic [2:0] f3, input logic jal, input logic jalr,
                              input logic lsr, input logic lsru, input logic eql,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic pred,
                              input logic [3:0] fl, input logic [31:0] link,
                              input logic [31:0] rpc);
    vec_t v;
    v.f3 = f3; v.jal = jal; v.jalr = jalr; v.lsr = lsr; v.lsru = lsru; v.eql = eql;
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.pred = pred; v.flags = fl; v.link = link; v.rpc = rpc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction for a single edge and queues what it should produce.
  task automatic accept(input vec_t v);
    funct3_i = v.f3; is_jal_i = v.jal; is_jalr_i = v.jalr;
    lsr_i = v.lsr; lsrU_i = v.lsru; eql_i = v.eql;
    pc_i = v.pc; imm_i = v.imm; rs1_i = v.rs1; pred_taken_i = v.pred;
    br_valid_i = 1'b1;
    exp_q.push_back(v);
    if (!v.flags[2]) exp_br++;
    if (v.flags[0]) exp_mis++;
    tick();
    br_valid_i = 1'b0;
  endtask

  task automatic finish_redirect();
    redir_ready_i = 1'b1;
    tick();
    redir_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({flags(), flush_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b required 00000", {flags(), flush_o});
    end
    checks++;
    if ({link_o, redir_pc_o} !== 64'h0) begin
      errors++; $display("FAIL reset_regs got link %h redir %h required 0", link_o, redir_pc_o);
    end
    checks++;
    if ({br_count_o, mispred_count_o} !== 32'h0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d required 0/0", br_count_o, mispred_count_o);
    end
    rst_n = 1'b1;
    checks++;
    if (br_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b required 1", br_ready_o);
    end
    tick();
    checks++;
    if ({br_ready_o, flags()} !== 5'b10000) begin
      errors++; $display("FAIL reset_idle got %b required 10000", {br_ready_o, flags()});
    end
    $display("test_reset done");
  endtask

  task automatic test_beq();
    accept(mk(3'b000, 0, 0, 0, 0, 1, 32'h100, 32'h20, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    e = exp_q.pop_front();
    checks++;
    if ({br_ready_o, flags()} !== {1'b1, e.flags}) begin
      errors++; $display("FAIL beq_flags got %b required %b", {br_ready_o, flags()}, {1'b1, e.flags});
    end
    checks++;
    if (br_count_o !== 16'(exp_br) || mispred_count_o !== 16'(exp_mis)) begin
      errors++; $display("FAIL beq_counts got %0d/%0d required %0d/%0d", br_count_o, mispred_count_o, exp_br, exp_mis);
    end
    $display("test_beq: taken=%b br=%0d mis=%0d", taken_o, br_count_o, mispred_count_o);
  endtask

  task automatic test_bltu_stall();
    accept(mk(3'b110, 0, 0, 0, 1, 0, 32'h200, 32'hFFFF_FFF0, 32'h0, 0, 4'b1001, 32'h0, 32'h1F0));
    e = exp_q.pop_front();
    checks++;
    if (flags() !== e.flags || redir_pc_o !== e.rpc) begin
      errors++; $display("FAIL bltu_redir got %b pc %h required %b pc %h", flags(), redir_pc_o, e.flags, e.rpc);
    end
    checks++;
    if (mispred_count_o !== 16'(exp_mis)) begin
      errors++; $display("FAIL bltu_mis got %0d required %0d", mispred_count_o, exp_mis);
    end
    // Offer a new instruction while stalled; it must be ignored.
    funct3_i = 3'b000; eql_i = 1'b1; pred_taken_i = 1'b1; pc_i = 32'h500;
    br_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({redir_valid_o, br_ready_o, flush_o} !== 3'b100 || redir_pc_o !== 32'h1F0) begin
        errors++; $display("FAIL bltu_stall%0d got v/r/f %b pc %h required 100 pc 000001f0", i, {redir_valid_o, br_ready_o, flush_o}, redir_pc_o);
      end
      checks++;
      if (br_count_o !== 16'(exp_br)) begin
        errors++; $display("FAIL bltu_stall_count%0d got %0d required %0d", i, br_count_o, exp_br);
      end
      tick();
    end
    br_valid_i = 1'b0;
    redir_ready_i = 1'b1;
    checks++;
    if ({redir_valid_o, redir_pc_o} !== {1'b1, 32'h1F0}) begin
      errors++; $display("FAIL bltu_hold got %b %h required 1 000001f0", redir_valid_o, redir_pc_o);
    end
    tick();
    redir_ready_i = 1'b0;
    checks++;
    if ({redir_valid_o, flush_o, br_ready_o} !== 3'b010) begin
      errors++; $display("FAIL bltu_flush got v/f/r %b required 010", {redir_valid_o, flush_o, br_ready_o});
    end
    tick();
    checks++;
    if ({redir_valid_o, flush_o, br_ready_o} !== 3'b001) begin
      errors++; $display("FAIL bltu_idle got v/f/r %b required 001", {redir_valid_o, flush_o, br_ready_o});
    end
    $display("test_bltu_stall: redirect 1f0 handshake complete, mis=%0d", mispred_count_o);
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    foreach (tbl[k]) begin
      accept(tbl[k]);
      e = exp_q.pop_front();
      checks++;
      if ({br_ready_o, flags()} !== {~e.flags[0], e.flags}) begin
        errors++; $display("FAIL %s%0d_flags got %b required %b", name, k, {br_ready_o, flags()}, {~e.flags[0], e.flags});
      end
      if (e.flags[0]) begin
        checks++;
        if (redir_pc_o !== e.rpc) begin
          errors++; $display("FAIL %s%0d_rpc got %h required %h", name, k, redir_pc_o, e.rpc);
        end
      end
      if (e.flags[1]) begin
        checks++;
        if (link_o !== e.link) begin
          errors++; $display("FAIL %s%0d_link got %h required %h", name, k, link_o, e.link);
        end
      end
      checks++;
      if (br_count_o !== 16'(exp_br) || mispred_count_o !== 16'(exp_mis)) begin
        errors++; $display("FAIL %s%0d_counts got %0d/%0d required %0d/%0d", name, k, br_count_o, mispred_count_o, exp_br, exp_mis);
      end
      $display("%s[%0d]: pc=%h flags=%b link=%h rpc=%h", name, k, tbl[k].pc, flags(), link_o, redir_pc_o);
      if (e.flags[0]) finish_redirect();
    end
  endtask

  task automatic test_bge_wrap();
    vec_t t[$];
    t.push_back(mk(3'b101, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h100, 32'h0, 1, 4'b0001, 32'h0, 32'h0));
    run_table("bge_wrap", t);
  endtask

  task automatic test_jumps();
    vec_t t[$];
    t.push_back(mk(3'b000, 0, 1, 0, 0, 0, 32'h40, 32'h4, 32'h1003, 1, 4'b1011, 32'h44, 32'h1006));
    t.push_back(mk(3'b000, 1, 0, 0, 0, 0, 32'h80, 32'h10, 32'h0, 1, 4'b1010, 32'h84, 32'h0));
    t.push_back(mk(3'b000, 1, 0, 0, 0, 0, 32'h300, 32'hFFFF_FF00, 32'h0, 0, 4'b1011, 32'h304, 32'h200));
    run_table("jump", t);
  endtask

  task automatic test_illegal();
    vec_t t[$];
    t.push_back(mk(3'b000, 0, 0, 0, 0, 1, 32'h600, 32'h8, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    t.push_back(mk(3'b010, 0, 0, 0, 0, 1, 32'h604, 32'h8, 32'h0, 0, 4'b0100, 32'h0, 32'h0));
    t.push_back(mk(3'b011, 0, 0, 1, 1, 0, 32'h608, 32'h8, 32'h0, 1, 4'b0100, 32'h0, 32'h0));
    t.push_back(mk(3'b000, 1, 1, 0, 0, 0, 32'h60C, 32'h8, 32'h0, 0, 4'b0100, 32'h0, 32'h0));
    t.push_back(mk(3'b001, 0, 0, 0, 0, 0, 32'h610, 32'h8, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    run_table("illegal", t);
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    t.push_back(mk(3'b001, 0, 0, 0, 0, 1, 32'h700, 32'h40, 32'h0, 0, 4'b0000, 32'h0, 32'h0));
    t.push_back(mk(3'b100, 0, 0, 1, 0, 0, 32'h704, 32'h40, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    t.push_back(mk(3'b111, 0, 0, 0, 1, 0, 32'h708, 32'h40, 32'h0, 0, 4'b0000, 32'h0, 32'h0));
    t.push_back(mk(3'b110, 0, 0, 1, 0, 1, 32'h70C, 32'h40, 32'h0, 0, 4'b0000, 32'h0, 32'h0));
    t.push_back(mk(3'b101, 0, 0, 0, 1, 0, 32'h710, 32'h40, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    run_table("b2b", t);
  endtask

  task automatic test_reset_mid_redirect();
    accept(mk(3'b000, 0, 1, 0, 0, 0, 32'h800, 32'h10, 32'h2000, 1, 4'b1011, 32'h804, 32'h2010));
    e = exp_q.pop_front();
    checks++;
    if (flags() !== e.flags || redir_pc_o !== e.rpc) begin
      errors++; $display("FAIL rstmid_pre got %b %h required %b %h", flags(), redir_pc_o, e.flags, e.rpc);
    end
    rst_n = 1'b0;
    tick();
    exp_br = 0; exp_mis = 0; exp_q.delete();
    checks++;
    if ({redir_valid_o, flush_o, link_valid_o} !== 3'b000 || redir_pc_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_redir got v/f/l %b pc %h required 000 pc 0", {redir_valid_o, flush_o, link_valid_o}, redir_pc_o);
    end
    checks++;
    if ({br_count_o, mispred_count_o} !== 32'h0) begin
      errors++; $display("FAIL rstmid_counts got %0d/%0d required 0/0", br_count_o, mispred_count_o);
    end
    rst_n = 1'b1;
    checks++;
    if (br_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b required 1", br_ready_o);
    end
    tick();
    checks++;
    if ({br_ready_o, redir_valid_o} !== 2'b10) begin
      errors++; $display("FAIL rstmid_after got r/v %b required 10", {br_ready_o, redir_valid_o});
    end
    $display("test_reset_mid_redirect: redirect dropped, counters cleared");
  endtask

  task automatic test_saturation();
    vec_t t[$];
    for (int i = 0; i < 5; i++)
      t.push_back(mk(3'b000, 0, 0, 0, 0, 1, 32'h900 + 32'(4 * i), 32'h8, 32'h0, 1, 4'b1000, 32'h0, 32'h0));
    for (int i = 0; i < 4; i++)
      t.push_back(mk(3'b000, 0, 1, 0, 0, 0, 32'hA00, 32'h0, 32'h3000 + 32'(16 * i), 1, 4'b1011, 32'hA04, 32'h3000 + 32'(16 * i)));
    run_table("sat", t);
    checks++;
    if (s_br_count !== 2'd3) begin
      errors++; $display("FAIL sat_br got %0d required 3", s_br_count);
    end
    checks++;
    if (s_mis_count !== 2'd3) begin
      errors++; $display("FAIL sat_mis got %0d required 3", s_mis_count);
    end
    checks++;
    if (br_count_o !== 16'd9 || mispred_count_o !== 16'd4) begin
      errors++; $display("FAIL sat_wide got %0d/%0d required 9/4", br_count_o, mispred_count_o);
    end
    $display("test_saturation: narrow %0d/%0d wide %0d/%0d", s_br_count, s_mis_count, br_count_o, mispred_count_o);
  endtask

  initial begin
    rst_n = 1'b0; br_valid_i = 1'b0; redir_ready_i = 1'b0;
    funct3_i = 3'b000; is_jal_i = 1'b0; is_jalr_i = 1'b0;
    lsr_i = 1'b0; lsrU_i = 1'b0; eql_i = 1'b0; pred_taken_i = 1'b0;
    pc_i = 32'h0; imm_i = 32'h0; rs1_i = 32'h0;
    test_reset();
    test_beq();
    test_bltu_stall();
    test_bge_wrap();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_mid_redirect();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumer of the EX-stage comparator flags (less-than signed, less-than unsigned, equal). The unit turns those flags plus the instruction's funct3 and jump type into a registered taken/not-taken decision. It compares that decision with the fetch-stage static prediction. On a mispredict it drives a held redirect request to fetch with a valid/ready handshake, then a one-cycle pipeline flush. It also produces the JAL/JALR link value and saturating branch/mispredict counters for the board debug view.

## Interface
- XLEN, 32, datapath/PC width
- CNT_W, 16, width of each statistics counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- br_valid_i  in  1  branch/jump instruction presented in EX
- br_ready_o  out  1  unit can accept an instruction this cycle
- funct3_i  in  3  branch funct3
- is_jal_i, is_jalr_i  in  1 each  jump type; both low means conditional branch
- lsr_i, lsrU_i, eql_i  in  1 each  comparator flags: rs1<rs2 signed, rs1<rs2 unsigned, rs1==rs2
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  sign-extended immediate
- rs1_i  in  XLEN  rs1 value, used for JALR
- pred_taken_i  in  1  fetch's static prediction for this instruction
- taken_o  out  1  registered resolved direction
- illegal_o  out  1  one-cycle pulse for an illegal encoding
- link_valid_o  out  1  one-cycle pulse; link_o is valid
- link_o  out  XLEN  pc+4 for the rd writeback
- redir_valid_o  out  1  redirect request to fetch
- redir_ready_i  in  1  fetch accepts the redirect
- redir_pc_o  out  XLEN  corrected fetch PC
- flush_o  out  1  one-cycle flush of IF/ID
- br_count_o  out  CNT_W  accepted legal branches/jumps
- mispred_count_o  out  CNT_W  mispredicts

## Operation
- Accept: br_valid_i & br_ready_o at a rising edge.
- Conditional taken rule:
  - 000 BEQ: eql
  - 001 BNE: !eql
  - 100 BLT: lsr
  - 101 BGE: !lsr
  - 110 BLTU: lsrU
  - 111 BGEU: !lsrU
- Illegal encodings: funct3 010 or 011 on a conditional, or is_jal_i & is_jalr_i both high.
  - Pulse illegal_o for one cycle.
  - Leave taken_o at 0.
  - No redirect, no counter update, stay in IDLE.
- Targets, all arithmetic modulo 2^XLEN with wrap and no overflow flag:
  - Branch and JAL: pc_i+imm_i.
  - JALR: (rs1_i+imm_i) with bit0 forced to 0.
  - Fall-through: pc_i+4.
- Mispredict rules:
  - Conditional: taken != pred_taken_i. redir_pc_o is the target if taken, otherwise pc_i+4.
  - JAL: always taken; mispredict iff pred_taken_i=0.
  - JALR: always a mispredict, since fetch has no target prediction.
- JAL/JALR: link_valid_o pulses with link_o=pc_i+4.
- FSM states:
  - IDLE: br_ready_o=1. Accept with no mispredict stays in IDLE, so back-to-back accepts are allowed. Accept with a mispredict goes to REDIRECT.
  - REDIRECT: br_ready_o=0, redir_valid_o=1. redir_pc_o is held stable until redir_valid_o & redir_ready_i at an edge, then go to FLUSH.
  - FLUSH: flush_o=1, br_ready_o=0, for one cycle, then IDLE.
- Counters: br_count_o increments on every legal accept. mispred_count_o increments on every mispredict accept. Both saturate at all-ones.

## Timing
- Reset (rst_n=0 at an edge, any state, including mid-REDIRECT):
  - State goes to IDLE.
  - taken_o, illegal_o, link_valid_o, redir_valid_o, flush_o, counters all reset to 0.
  - link_o and redir_pc_o reset to 0.
  - br_ready_o=1 in the first cycle after reset release.
  - A pending redirect is dropped.
- Latency: for an accept at edge N, taken_o, illegal_o, link_valid_o/link_o and redir_valid_o/redir_pc_o are valid in cycle N+1 and the counters reflect it in cycle N+1.
- Minimum mispredict sequence: accept at N, redirect handshake at end of N+1, flush_o high in N+2, br_ready_o high again in N+3.
- redir_ready_i stalled low: stay in REDIRECT indefinitely with outputs stable and nothing new accepted.
- br_valid_i while br_ready_o=0 is ignored. Upstream must hold the instruction.
- taken_o holds its last value until the next accept.

## Test plan
- BEQ pc=0x100, imm=0x20, eql=1, pred=1 -> taken_o=1 in N+1, no redir_valid_o, br_count_o=1, mispred_count_o=0, br_ready_o stays 1.
- BLTU lsrU=1, pred=0, pc=0x200, imm=0xFFFFFFF0, redir_ready_i held 0 for 3 cycles -> redir_valid_o=1 with redir_pc_o=0x1F0 stable throughout; after ready, flush_o high exactly 1 cycle; mispred_count_o=1.
- BGE lsr=1 (not taken), pred=1, pc=0xFFFFFFFC -> redir_pc_o=0x00000000 (wrap).
- JALR rs1=0x1003, imm=0x4, pc=0x40 -> redir_pc_o=0x1006, link_valid_o pulse with link_o=0x44, mispredict counted.
- funct3=010 -> illegal_o one-cycle pulse, counters unchanged, no redirect, next instruction accepted in N+1.
- rst_n low during REDIRECT -> redir_valid_o=0 in the next cycle, counters 0, br_ready_o=1 after release; counter saturation checked with CNT_W=2 (stays 3 after 5 branches).
